// File: rtl/laplace_pkg.sv
// Shared helpers for the streaming stencil kernels: output-mode codes and
// the approximate adder / saturation functions reused by later filters.
package laplace_pkg;

    // Output mode selectors
    localparam int MODE_CLAMP = 0;
    localparam int MODE_ABS   = MODE_CLAMP + 1;

    // Approximate add: the low k bits are ORed (no carry out of them), the
    // remaining upper bits are added exactly. k = 0 is a plain exact add.
    function automatic logic [31:0] apx_add(
        input logic [31:0] x,
        input logic [31:0] y,
        input int          k
    );
        logic [31:0] mask;
        mask = (32'd1 << k) - 32'd1;
        return (((x >> k) + (y >> k)) << k) | ((x | y) & mask);
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^w - 1].
    function automatic logic [31:0] sat_clamp(
        input logic signed [31:0] diff,
        input int                 w
    );
        logic signed [31:0] maxv;
        maxv = (32'sd1 <<< w) - 32'sd1;
        if (diff < 0) begin
            return '0;
        end else if (diff > maxv) begin
            return 32'(maxv);
        end else begin
            return 32'(diff);
        end
    endfunction

endpackage

// File: rtl/laplace_line_buffer.sv
// One-line delay: dout presents the pixel written DEPTH enables earlier.
// Storage is never reset; consumers gate on their own row counters.
module laplace_line_buffer #(
    parameter int PIX_W = 8,
    parameter int DEPTH = 640
) (
    input  logic             clk,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    logic [PIX_W-1:0] tap_q [DEPTH];

    // Shift the whole line by one position on each accepted pixel
    always_ff @(posedge clk) begin
        if (en) begin
            tap_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                tap_q[i] <= tap_q[i-1];
            end
        end
    end

    assign dout = tap_q[DEPTH-1];

endmodule

// File: rtl/laplace5_stream.sv
// Streaming 5-point Laplace filter (b + d + f + h - 4e) over a raster stream.
// Two line buffers plus a few tap registers form the window; a two-stage
// pipeline (pair sums, then final sum/saturate) produces interior pixels.
// The whole datapath freezes while the output register is held by backpressure.
module laplace5_stream
    import laplace_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int APX_LSB  = 3,
    parameter int OUT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic             stall;
    logic             accept;
    logic             ready_q;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             win_valid;
    logic             win_last;
    logic [PIX_W-1:0] line1_dout, line2_dout;
    logic [PIX_W-1:0] b_q, d_q, e_q, h_q;
    logic             s1_valid_q, s1_last_q;
    logic [PIX_W:0]   p1_q, p2_q;
    logic [PIX_W-1:0] s1_e_q;
    logic [PIX_W+1:0] sum_d;
    logic signed [PIX_W+2:0] diff_d;
    logic signed [PIX_W+2:0] mag_d;
    logic [PIX_W-1:0] out_pix_d;
    logic             out_valid_q, out_last_q;
    logic [PIX_W-1:0] out_pix_q;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ready_q & ~stall;
    assign accept   = in_valid & in_ready;

    // Hold off input acceptance until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Raster position of the pixel being accepted; wraps per line and frame
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Position counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Window centre lies one row and one column behind the incoming pixel
    assign win_valid = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign win_last  = (row_q == ROW_LAST) && (col_q == COL_LAST);

    laplace_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_line1 (
        .clk  (clk),
        .en   (accept),
        .din  (in_pix),
        .dout (line1_dout)
    );

    laplace_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_line2 (
        .clk  (clk),
        .en   (accept),
        .din  (line1_dout),
        .dout (line2_dout)
    );

    // Column-delay taps completing the cross: b, d, e and h of the window
    always_ff @(posedge clk) begin
        if (accept) begin
            h_q <= in_pix;
            e_q <= line1_dout;
            d_q <= e_q;
            b_q <= line2_dout;
        end
    end

    // Stage 1: pairwise approximate sums, centre carried alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            p1_q       <= '0;
            p2_q       <= '0;
            s1_e_q     <= '0;
        end else if (!stall) begin
            s1_valid_q <= accept & win_valid;
            s1_last_q  <= accept & win_last;
            if (accept) begin
                p1_q   <= (PIX_W+1)'(apx_add(32'(b_q), 32'(d_q), APX_LSB));
                p2_q   <= (PIX_W+1)'(apx_add(32'(line1_dout), 32'(h_q), APX_LSB));
                s1_e_q <= e_q;
            end
        end
    end

    // Stage 2 combinational: final sum, subtract 4e, map to output range
    always_comb begin
        sum_d  = (PIX_W+2)'(apx_add(32'(p1_q), 32'(p2_q), APX_LSB));
        diff_d = $signed({1'b0, sum_d}) - $signed({1'b0, s1_e_q, 2'b00});
        mag_d  = diff_d;
        if (OUT_MODE == MODE_ABS && diff_d < 0) begin
            mag_d = -diff_d;
        end
        out_pix_d = PIX_W'(sat_clamp(32'(mag_d), PIX_W));
    end

    // Output register; holds while downstream is not ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_pix_q   <= '0;
        end else if (!stall) begin
            out_valid_q <= s1_valid_q;
            out_last_q  <= s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                out_pix_q <= out_pix_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/laplace5_stream.md
Name: laplace5_stream

Overview:
- Streaming 5-point Laplace filter, s = b + d + f + h − 4e, over a raster pixel stream. It is the parametrised successor of the combinational 5-point approximate kernel.
- Adds internal line buffers, valid/ready handshake, configurable pixel width and image size, a tunable approximate-adder LSB count, and a selectable output mode (clamp or absolute).
- Sits between the pixel source (frame reader) and the output writer in the filter datapath.

Parameters:
- PIX_W, 8, pixel width in bits (unsigned).
- IMG_W, 640, pixels per line (≥3).
- IMG_H, 480, lines per frame (≥3).
- APX_LSB, 3, number of LSBs in each pairwise add computed as bitwise OR, with no carry out of them. 0 = exact.
- OUT_MODE, 0, 0 = clamp the signed result to [0, 2^PIX_W−1]; 1 = |result| saturated to 2^PIX_W−1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_pix  in  PIX_W  input pixel, raster order.
- out_valid  out  1  filtered pixel valid.
- out_ready  in  1  downstream accepts.
- out_pix  out  PIX_W  filtered interior pixel.
- out_last  out  1  high on the final output pixel of a frame.

Behaviour:
- Reset: one clock, reset asynchronous active-low. On reset:
  - out_valid=0, out_pix=0, out_last=0.
  - col/row counters=0, pipeline valids=0.
  - Line-buffer RAM contents are not cleared; they are don't-care because output is gated by the row counter.
  - in_ready=1 one cycle after rst_n deasserts.
  - Reset mid-frame discards the partial frame; the next accepted pixel is treated as (0,0).
- Accept and stall:
  - Accept = in_valid & in_ready.
  - Global stall = out_valid & ~out_ready.
  - in_ready = ~stall. When stalled, all registers and line buffers hold.
- Counters:
  - col increments per accept and wraps at IMG_W−1 → 0, which increments row.
  - row wraps at IMG_H−1 → 0 (next frame). Frames are back-to-back with no gap required.
- Window: when pixel (r,c) is accepted, the centre is (r−1,c−1):
  - b = line2[c−1], d = line1[c−2], e = line1[c−1], f = line1[c], h = cur[c−1].
  - line1 holds row r−1 and line2 holds row r−2. Both are IMG_W-deep shift/RAM buffers written on accept.
- Window validity: the window is valid iff r≥2 and c≥2. Border centres produce no output.
  - Output frame is (IMG_W−2)×(IMG_H−2) pixels.
- Pipeline, stage 1 (registered): p1 = add(b,d), p2 = add(f,h), each PIX_W+1 bits. e is registered alongside.
- add(x,y) when APX_LSB=k:
  - result[k−1:0] = x[k−1:0] | y[k−1:0].
  - result[PIX_W:k] = x[PIX_W−1:k] + y[PIX_W−1:k].
  - No carry crosses bit k.
  - k=0 gives an exact add. Legal range is 0..PIX_W−1.
- Pipeline, stage 2 (registered output):
  - sum = add'(p1,p2), a PIX_W+2-bit add using the same LSB rule.
  - diff = sum − (e<<2), computed signed in PIX_W+3 bits.
  - OUT_MODE 0: out = diff<0 ? 0 : diff>max ? max : diff.
  - OUT_MODE 1: out = min(|diff|, max).
- Latency: the output appears 2 cycles after the accept of window pixel (r,c), absent stalls.
- out_last = 1 exactly for centre (IMG_H−2, IMG_W−2), i.e. on accept of (IMG_H−1, IMG_W−1). It travels with the data.
- Simultaneous accept and output-consume in the same cycle is legal; sustained throughput is 1 pixel/cycle.
- in_valid low bubbles propagate as pipeline bubbles; counters advance only on accept.

Decomposition:
- Shared package laplace_pkg holds:
  - OUT_MODE constants MODE_CLAMP=0 and MODE_ABS=0+1.
  - Functions apx_add(x,y,k) and sat_clamp(diff,PIX_W) for reuse by later kernels.
- Sub-module laplace_line_buffer (params PIX_W, DEPTH=IMG_W; ports clk, en, din, dout).
  - One-line delay, no reset on storage.
  - Instantiated twice (line1, line2).

Test Plan:
- PIX_W=8, IMG_W=8, IMG_H=6, APX_LSB=0: constant frame of 100 → 24 outputs, all 0, out_last only on output 24.
- Exact mode, single centre e=10 with b=d=f=h=50 (all other pixels 0) → that centre outputs 160. Its neighbours (e=50, one neighbour 10) output 0 via clamp.
- Overflow: b=d=f=h=255, e=0 → 1020 clamped to 255. Underflow: e=255, neighbours 0 → OUT_MODE 0 gives 0, OUT_MODE 1 gives 255 (|−1020| saturated).
- APX_LSB=3: b=d=f=h=7, e=0 → p1=p2=7 (OR), sum=7 → out 7 (exact would be 28). Compare every output against a golden model with the same apx_add.
- Random out_ready (50%) and in_valid (70%) over 3 back-to-back frames → output stream identical to the no-stall run, in_ready==~(out_valid&~out_ready) every cycle.
- Assert rst_n low mid-frame (after 20 pixels), then send a full frame → outputs begin at the new frame's (2,2) centre, exactly 24 outputs, no stale data.
